// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, control-word encodings and CCR bit positions.
// Imported by the datapath, its ALU and the control unit.
package cpu_pkg;

    localparam int CPU_DATA_W = 8;
    localparam int CPU_FLAG_W = 4;

    // CCR bit positions, order {N,Z,V,C}
    localparam int CCR_N = 3;
    localparam int CCR_Z = 2;
    localparam int CCR_V = 1;
    localparam int CCR_C = 0;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_INCA = 3'b100,
        ALU_INCB = 3'b101,
        ALU_DECA = 3'b110,
        ALU_DECB = 3'b111
    } alu_sel_e;

    typedef enum logic [1:0] {
        TO_PC   = 2'b00,
        TO_A    = 2'b01,
        TO_B    = 2'b10,
        TO_ZERO = 2'b11
    } to_sel_e;

    typedef enum logic [1:0] {
        FROM_ALU  = 2'b00,
        FROM_TO   = 2'b01,
        FROM_MEM  = 2'b10,
        FROM_ZERO = 2'b11
    } from_sel_e;

    // Opcodes decoded by the control unit from IR
    localparam logic [7:0] OP_LDA_IMM = 8'h86;
    localparam logic [7:0] OP_LDA_DIR = 8'h87;
    localparam logic [7:0] OP_LDB_IMM = 8'h88;
    localparam logic [7:0] OP_LDB_DIR = 8'h89;
    localparam logic [7:0] OP_STA_DIR = 8'h96;
    localparam logic [7:0] OP_STB_DIR = 8'h97;
    localparam logic [7:0] OP_ADD_AB  = 8'h42;
    localparam logic [7:0] OP_SUB_AB  = 8'h43;
    localparam logic [7:0] OP_AND_AB  = 8'h44;
    localparam logic [7:0] OP_OR_AB   = 8'h45;
    localparam logic [7:0] OP_INCA    = 8'h46;
    localparam logic [7:0] OP_INCB    = 8'h47;
    localparam logic [7:0] OP_DECA    = 8'h48;
    localparam logic [7:0] OP_DECB    = 8'h49;
    localparam logic [7:0] OP_BRA     = 8'h20;
    localparam logic [7:0] OP_BMI     = 8'h21;
    localparam logic [7:0] OP_BPL     = 8'h22;
    localparam logic [7:0] OP_BEQ     = 8'h23;
    localparam logic [7:0] OP_BNE     = 8'h24;
    localparam logic [7:0] OP_BVS     = 8'h25;
    localparam logic [7:0] OP_BVC     = 8'h26;
    localparam logic [7:0] OP_BCS     = 8'h27;
    localparam logic [7:0] OP_BCC     = 8'h28;

endpackage

// File: rtl/data_path_if.sv
// Control word and memory/decode signals between the control unit, memory and the datapath.
// master = control unit side (drives the control word and memory read data), slave = datapath.
interface data_path_if #(
  parameter int DATA_W = 8,
  parameter int FLAG_W = 4
);
  logic              IR_LOAD;
  logic              MAR_LOAD;
  logic              PC_LOAD;
  logic              PC_INC;
  logic              A_LOAD;
  logic              B_LOAD;
  logic [2:0]        ALU_SEL;
  logic              CCR_LOAD;
  logic [1:0]        TO_MEMORY_BUS_SEL;
  logic [1:0]        FROM_MEMORY_BUS_SEL;
  logic [DATA_W-1:0] from_memory;
  logic [DATA_W-1:0] address;
  logic [DATA_W-1:0] to_memory;
  logic [DATA_W-1:0] IR;
  logic [FLAG_W-1:0] CCR;

  modport master (
    output IR_LOAD, MAR_LOAD, PC_LOAD, PC_INC, A_LOAD, B_LOAD, ALU_SEL, CCR_LOAD,
    output TO_MEMORY_BUS_SEL, FROM_MEMORY_BUS_SEL, from_memory,
    input  address, to_memory, IR, CCR
  );

  modport slave (
    input  IR_LOAD, MAR_LOAD, PC_LOAD, PC_INC, A_LOAD, B_LOAD, ALU_SEL, CCR_LOAD,
    input  TO_MEMORY_BUS_SEL, FROM_MEMORY_BUS_SEL, from_memory,
    output address, to_memory, IR, CCR
  );
endinterface

// File: rtl/data_path_alu.sv
// Combinational ALU: X = A, Y = B. Every arithmetic op is reduced to p +/- q so that
// carry/borrow and overflow come from one adder and one pair of sign rules.
module alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] X,
  input  logic [DATA_W-1:0] Y,
  input  logic [2:0]        ALU_SEL,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        NZVC
);
  logic [DATA_W-1:0] w_p;
  logic [DATA_W-1:0] w_q;
  logic              w_sub;
  logic              w_logic;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_res;
  logic              w_c;
  logic              w_v;

  always_comb begin
    w_p     = X;
    w_q     = Y;
    w_sub   = 1'b0;
    w_logic = 1'b0;
    case (alu_sel_e'(ALU_SEL))
      ALU_ADD:  begin w_p = X; w_q = Y; end
      ALU_SUB:  begin w_p = X; w_q = Y; w_sub = 1'b1; end
      ALU_AND:  w_logic = 1'b1;
      ALU_OR:   w_logic = 1'b1;
      ALU_INCA: begin w_p = X; w_q = DATA_W'(1); end
      ALU_INCB: begin w_p = Y; w_q = DATA_W'(1); end
      ALU_DECA: begin w_p = X; w_q = DATA_W'(1); w_sub = 1'b1; end
      ALU_DECB: begin w_p = Y; w_q = DATA_W'(1); w_sub = 1'b1; end
      default:  w_logic = 1'b1;
    endcase
  end

  // Bit DATA_W of the 9-bit difference is set exactly when p < q (unsigned borrow).
  assign w_sum = w_sub ? ({1'b0, w_p} - {1'b0, w_q}) : ({1'b0, w_p} + {1'b0, w_q});

  always_comb begin
    w_res = w_sum[DATA_W-1:0];
    w_c   = w_sum[DATA_W];
    if (w_sub)
      w_v = (w_p[DATA_W-1] != w_q[DATA_W-1]) && (w_res[DATA_W-1] != w_p[DATA_W-1]);
    else
      w_v = (w_p[DATA_W-1] == w_q[DATA_W-1]) && (w_res[DATA_W-1] != w_p[DATA_W-1]);
    if (w_logic) begin
      w_res = (ALU_SEL == ALU_AND) ? (X & Y) : (X | Y);
      w_c   = 1'b0;
      w_v   = 1'b0;
    end
  end

  assign result       = w_res;
  assign NZVC[CCR_N]  = w_res[DATA_W-1];
  assign NZVC[CCR_Z]  = (w_res == '0);
  assign NZVC[CCR_V]  = w_v;
  assign NZVC[CCR_C]  = w_c;
endmodule

// File: rtl/data_path.sv
// 8-bit CPU datapath: PC, MAR, IR, A, B, CCR, the TO/FROM buses and the ALU.
// Executes one control word per clock; every register samples the FROM bus.
module data_path
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int FLAG_W = 4
) (
  input  logic         clk,
  input  logic         reset,
  data_path_if.slave   bus
);
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_mar;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [FLAG_W-1:0] r_ccr;

  logic [DATA_W-1:0] w_to_bus;
  logic [DATA_W-1:0] w_from_bus;
  logic [DATA_W-1:0] w_alu_result;
  logic [3:0]        w_alu_nzvc;

  alu #(.DATA_W(DATA_W)) u_alu (
    .X       (r_a),
    .Y       (r_b),
    .ALU_SEL (bus.ALU_SEL),
    .result  (w_alu_result),
    .NZVC    (w_alu_nzvc)
  );

  always_comb begin
    case (to_sel_e'(bus.TO_MEMORY_BUS_SEL))
      TO_PC:   w_to_bus = r_pc;
      TO_A:    w_to_bus = r_a;
      TO_B:    w_to_bus = r_b;
      default: w_to_bus = '0;
    endcase
  end

  always_comb begin
    case (from_sel_e'(bus.FROM_MEMORY_BUS_SEL))
      FROM_ALU: w_from_bus = w_alu_result;
      FROM_TO:  w_from_bus = w_to_bus;
      FROM_MEM: w_from_bus = bus.from_memory;
      default:  w_from_bus = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc  <= '0;
      r_mar <= '0;
      r_ir  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_ccr <= '0;
    end else begin
      if (bus.IR_LOAD)  r_ir  <= w_from_bus;
      if (bus.MAR_LOAD) r_mar <= w_from_bus;
      if (bus.A_LOAD)   r_a   <= w_from_bus;
      if (bus.B_LOAD)   r_b   <= w_from_bus;
      // A branch target outranks the sequential increment.
      if (bus.PC_LOAD)
        r_pc <= w_from_bus;
      else if (bus.PC_INC)
        r_pc <= r_pc + DATA_W'(1);
      if (bus.CCR_LOAD) r_ccr <= FLAG_W'(w_alu_nzvc);
    end
  end

  assign bus.address   = r_mar;
  assign bus.to_memory = w_to_bus;
  assign bus.IR        = r_ir;
  assign bus.CCR       = r_ccr;
endmodule

// File: doc/data_path.md
# data_path

8-bit CPU datapath that executes the per-cycle control word issued by the control unit. It owns the program counter, MAR, IR, A, B and CCR registers, the two internal buses and the ALU. It presents `address` and `to_memory` to the memory system and returns `IR` and `CCR` to the control unit for decode and branch decisions.

## Interface
Parameters:
- `DATA_W`, 8, width of registers, buses and memory data.
- `FLAG_W`, 4, CCR width, bit order {N,Z,V,C} (bit 3 = N, bit 0 = C).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears every register immediately.
- `IR_LOAD`  in  1  IR <= FROM bus.
- `MAR_LOAD`  in  1  MAR <= FROM bus.
- `PC_LOAD`  in  1  PC <= FROM bus (branch target).
- `PC_INC`  in  1  PC <= PC + 1.
- `A_LOAD`  in  1  A <= FROM bus.
- `B_LOAD`  in  1  B <= FROM bus.
- `ALU_SEL`  in  3  ALU operation select.
- `CCR_LOAD`  in  1  CCR <= ALU flags.
- `TO_MEMORY_BUS_SEL`  in  2  source select for the TO bus.
- `FROM_MEMORY_BUS_SEL`  in  2  source select for the FROM bus.
- `from_memory`  in  8  read data from memory. Valid one cycle after `address` changes.
- `address`  out  8  memory address, driven directly by MAR.
- `to_memory`  out  8  TO bus; write data to memory.
- `IR`  out  8  instruction register.
- `CCR`  out  4  condition codes {N,Z,V,C}.

## Operation
- TO bus mux:
  - 00: PC
  - 01: A
  - 10: B
  - 11: 8'h00
- FROM bus mux:
  - 00: ALU result
  - 01: TO bus
  - 10: `from_memory`
  - 11: 8'h00
- All load enables sample the FROM bus. Several enables may be active in one cycle; each enabled register loads the same FROM value.
- PC priority:
  - PC_LOAD beats PC_INC when both are asserted.
  - PC wraps 8'hFF -> 8'h00 on increment.
  - Neither asserted: PC holds.
- ALU is combinational. Operands are X = A and Y = B, taken as current register values. Operations by ALU_SEL:
  - 000: X+Y
  - 001: X−Y
  - 010: X&Y
  - 011: X|Y
  - 100: X+1
  - 101: Y+1
  - 110: X−1
  - 111: Y−1
- Flag rules:
  - N = result[7].
  - Z = (result == 0).
  - C: carry out of bit 7 for add/inc. For sub/dec, C = 1 iff an unsigned borrow occurs (X<Y for sub; operand == 0 for dec).
  - V: two's-complement overflow. Add: operands share a sign and the result sign differs. Sub: operand signs differ and the result sign differs from X. Inc/dec: treated as add/sub of 1.
  - AND/OR: V = 0, C = 0.
- Flags affect state only through CCR_LOAD. Without CCR_LOAD, CCR holds.
- Reset values: PC, MAR, IR, A, B = 8'h00 and CCR = 4'h0. Therefore `address` = 8'h00, `to_memory` = 8'h00 (PC selected when the TO select is 00), `IR` = 0, `CCR` = 0.
- Reset asserted mid-instruction clears all state asynchronously. After deassertion, the first enabled edge behaves as from power-up.

## Timing
- Every register output changes only at the rising edge where its enable is high. Outputs are registered, except `to_memory`, which is combinational from the TO bus.
- Read-modify in one cycle: A_LOAD with FROM sel 00 writes the ALU result computed from pre-edge A/B. If CCR_LOAD is also asserted, the flags of that same result are captured.
- Fetch sequence contract (1-cycle memory latency):
  - cycle n: MAR_LOAD, FROM sel 01, TO sel 00 -> `address` = PC at edge n+1.
  - cycle n+1: PC_INC.
  - cycle n+2: IR_LOAD, FROM sel 10 -> IR = memory[old PC] at edge n+3.
- Branch: PC_LOAD with FROM sel 10 captures the operand in one edge.
- Stores: `to_memory` is valid in the same cycle the TO select changes, so the external write can be asserted that cycle.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants;
  - ALU_SEL encodings;
  - TO/FROM mux encodings;
  - CCR bit indices (N=3, Z=2, V=1, C=0).
- The control unit imports the same package.
- One sub-module, `alu`: combinational, ports X, Y, ALU_SEL -> result[7:0], NZVC[3:0].
- Registers and muxes stay in `data_path`.

## Test plan
- Reset mid-run, with A = 8'h5A and PC = 8'h10 -> all outputs 0 immediately, before the next clock.
- Fetch: PC = 8'h00, memory[0] = 8'h10, drive the 3-cycle fetch sequence -> `address` = 8'h00, then PC = 8'h01, then IR = 8'h10.
- Add overflow: A = 8'h7F, B = 8'h01, ALU_SEL 000, A_LOAD + CCR_LOAD, FROM sel 00 -> A = 8'h80, CCR = 4'b1010.
- Sub and dec boundaries:
  - A = 8'h00, B = 8'h01, SUB -> A = 8'hFF, CCR = 4'b1001.
  - A = 8'h01, DECA -> A = 8'h00, CCR = 4'b0100.
- PC priority/wrap:
  - PC = 8'hFF, PC_INC -> 8'h00.
  - PC_LOAD + PC_INC together, FROM = `from_memory` = 8'h42 -> PC = 8'h42.
- Store path: B = 8'h3C, TO sel 10 -> `to_memory` = 8'h3C in the same cycle. With MAR_LOAD + FROM sel 01 asserted, MAR = 8'h3C at the next edge.
